// File: rtl/writeback_arb_pkg.sv
// Shared constants for the swt16 writeback stage: default widths, arbiter
// mode encodings and a helper that sizes the round-robin pointer.
package writeback_arb_pkg;

    localparam int unsigned IALU_WORD_WIDTH_DEF = 16;
    localparam int unsigned REG_IDX_WIDTH_DEF   = 4;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    // Pointer needs at least one bit even for a single source.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/writeback_arb_arbiter.sv
// wb_rr_arbiter: turns the source valid vector into a one-hot (or zero) grant.
// Fixed mode grants the lowest valid index. Round-robin mode searches from the
// pointer with wrap, then moves the pointer one past the granted source.
//   clock  in   core clock
//   reset  in   asynchronous active-low reset (grant forced to 0 while low)
//   valid  in   NUM_SRC request vector
//   grant  out  NUM_SRC one-hot grant
module wb_rr_arbiter
    import writeback_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned ARB_MODE = ARB_FIXED
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] valid,
    output logic [NUM_SRC-1:0] grant
);

    localparam int unsigned PW = ptr_width(NUM_SRC);

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;

    always_comb begin
        int unsigned k;
        grant   = '0;
        ptr_nxt = ptr;
        k       = 0;
        if (ARB_MODE == ARB_RR) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                k = int'(ptr) + i;
                if (k >= NUM_SRC) k = k - NUM_SRC;
                if (grant == '0 && valid[k]) begin
                    grant[k] = 1'b1;
                    ptr_nxt  = (k + 1 == NUM_SRC) ? '0 : PW'(k + 1);
                end
            end
        end else begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (grant == '0 && valid[i]) grant[i] = 1'b1;
            end
        end
        if (!reset) grant = '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (grant != '0) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/writeback_arb.sv
// writeback_arb: arbitrates NUM_SRC result producers onto the single register
// file write port. An accepted result is driven on the port for exactly one
// cycle after the accepting edge; the forwarding valid mirrors the write enable.
//   clock                     in   core clock
//   reset                     in   asynchronous active-low reset
//   in_flush                  in   squash the write being registered this cycle
//   in_valid                  in   per-source result valid
//   in_res                    in   packed results, src i at [i*W +: W]
//   in_res_reg_idx            in   packed destination indices
//   out_ready                 out  one-hot (or zero) grant
//   out_act_write_res_to_reg  out  register file write enable
//   out_res                   out  write data (qualify with enable)
//   out_res_reg_idx           out  write index (qualify with enable)
//   out_fwd_valid             out  forwarding valid, equals write enable
//   out_acc_cnt               out  packed per-source accept counters
module writeback_arb
    import writeback_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC         = 2,
    parameter int unsigned IALU_WORD_WIDTH = IALU_WORD_WIDTH_DEF,
    parameter int unsigned REG_IDX_WIDTH   = REG_IDX_WIDTH_DEF,
    parameter int unsigned ARB_MODE        = ARB_FIXED,
    parameter int unsigned ZERO_REG_RO     = 1,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               in_flush,
    input  logic [NUM_SRC-1:0]                 in_valid,
    input  logic [NUM_SRC*IALU_WORD_WIDTH-1:0] in_res,
    input  logic [NUM_SRC*REG_IDX_WIDTH-1:0]   in_res_reg_idx,
    output logic [NUM_SRC-1:0]                 out_ready,
    output logic                               out_act_write_res_to_reg,
    output logic [IALU_WORD_WIDTH-1:0]         out_res,
    output logic [REG_IDX_WIDTH-1:0]           out_res_reg_idx,
    output logic                               out_fwd_valid,
    output logic [NUM_SRC*CNT_WIDTH-1:0]       out_acc_cnt
);

    logic [NUM_SRC-1:0]         grant;
    logic                       accept;
    logic [IALU_WORD_WIDTH-1:0] sel_res;
    logic [REG_IDX_WIDTH-1:0]   sel_idx;
    logic                       act_d;
    logic                       act_q;
    logic [IALU_WORD_WIDTH-1:0] res_q;
    logic [REG_IDX_WIDTH-1:0]   idx_q;
    logic [CNT_WIDTH-1:0]       cnt [NUM_SRC];

    wb_rr_arbiter #(
        .NUM_SRC  (NUM_SRC),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clock (clock),
        .reset (reset),
        .valid (in_valid),
        .grant (grant)
    );

    assign out_ready = grant;
    assign accept    = (grant != '0);

    always_comb begin
        sel_res = '0;
        sel_idx = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                sel_res = in_res[i*IALU_WORD_WIDTH +: IALU_WORD_WIDTH];
                sel_idx = in_res_reg_idx[i*REG_IDX_WIDTH +: REG_IDX_WIDTH];
            end
        end
    end

    // Register-0 writes and flushed writes still consume the grant but never
    // raise the enable.
    assign act_d = accept && !in_flush &&
                   !((ZERO_REG_RO != 0) && (sel_idx == '0));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            act_q <= 1'b0;
            res_q <= '0;
            idx_q <= '0;
        end else begin
            act_q <= act_d;
            if (act_d) begin
                res_q <= sel_res;
                idx_q <= sel_idx;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (grant[i]) cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        out_acc_cnt = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            out_acc_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
        end
    end

    assign out_act_write_res_to_reg = act_q;
    assign out_fwd_valid            = act_q;
    assign out_res                  = res_q;
    assign out_res_reg_idx          = idx_q;

endmodule

// File: tb/tb_writeback_arb.sv
// Directed bench for writeback_arb: a 2-source fixed-priority instance (a) and
// a 3-source round-robin instance with 4-bit counters (b) share clock, reset
// and flush.
module tb_writeback_arb;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_flush = 1'b0;

    logic [1:0]  a_valid = '0;
    logic [31:0] a_res = '0;
    logic [7:0]  a_idx = '0;
    logic [1:0]  a_ready;
    logic        a_act;
    logic [15:0] a_out_res;
    logic [3:0]  a_out_idx;
    logic        a_fwd;
    logic [31:0] a_cnt;

    logic [2:0]  b_valid = '0;
    logic [47:0] b_res = '0;
    logic [11:0] b_idx = '0;
    logic [2:0]  b_ready;
    logic        b_act;
    logic [15:0] b_out_res;
    logic [3:0]  b_out_idx;
    logic        b_fwd;
    logic [11:0] b_cnt;

    int unsigned total = 0;
    int unsigned passed = 0;

    always #5 clock = ~clock;

    writeback_arb #(
        .NUM_SRC(2), .IALU_WORD_WIDTH(16), .REG_IDX_WIDTH(4),
        .ARB_MODE(0), .ZERO_REG_RO(1), .CNT_WIDTH(16)
    ) dut_a (
        .clock(clock), .reset(reset), .in_flush(in_flush),
        .in_valid(a_valid), .in_res(a_res), .in_res_reg_idx(a_idx),
        .out_ready(a_ready), .out_act_write_res_to_reg(a_act),
        .out_res(a_out_res), .out_res_reg_idx(a_out_idx),
        .out_fwd_valid(a_fwd), .out_acc_cnt(a_cnt)
    );

    writeback_arb #(
        .NUM_SRC(3), .IALU_WORD_WIDTH(16), .REG_IDX_WIDTH(4),
        .ARB_MODE(1), .ZERO_REG_RO(1), .CNT_WIDTH(4)
    ) dut_b (
        .clock(clock), .reset(reset), .in_flush(in_flush),
        .in_valid(b_valid), .in_res(b_res), .in_res_reg_idx(b_idx),
        .out_ready(b_ready), .out_act_write_res_to_reg(b_act),
        .out_res(b_out_res), .out_res_reg_idx(b_out_idx),
        .out_fwd_valid(b_fwd), .out_acc_cnt(b_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [2:0] rr_exp [6];
        rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100;
        rr_exp[3] = 3'b001; rr_exp[4] = 3'b010; rr_exp[5] = 3'b100;

        // 1. ready held low during reset even with a request present
        a_valid = 2'b01;
        #2;
        chk("ready_in_reset", 64'(a_ready), 64'h0);
        tick();
        a_valid = '0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_act",   64'(a_act),     64'h0);
            chk("rst_ready", 64'(a_ready),   64'h0);
            chk("rst_res",   64'(a_out_res), 64'h0);
            chk("rst_cnt_a", 64'(a_cnt),     64'h0);
            chk("rst_cnt_b", 64'(b_cnt),     64'h0);
        end

        // 2. single accept from src0
        a_valid = 2'b01; a_res = {16'h0, 16'hBEEF}; a_idx = 8'h03;
        #1;
        chk("single_ready", 64'(a_ready), 64'h1);
        tick();
        a_valid = '0;
        chk("single_act", 64'(a_act),     64'h1);
        chk("single_fwd", 64'(a_fwd),     64'h1);
        chk("single_res", 64'(a_out_res), 64'hBEEF);
        chk("single_idx", 64'(a_out_idx), 64'h3);
        tick();
        chk("single_act_off", 64'(a_act), 64'h0);
        chk("single_cnt", 64'(a_cnt), 64'h0000_0001);

        // 3. fixed priority: src0 always wins
        a_valid = 2'b11; a_res = {16'h2222, 16'h1111}; a_idx = 8'h21;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fixed_ready", 64'(a_ready), 64'h1);
            tick();
            chk("fixed_res", 64'(a_out_res), 64'h1111);
            chk("fixed_idx", 64'(a_out_idx), 64'h1);
        end
        a_valid = '0;
        tick();
        chk("fixed_cnt", 64'(a_cnt), 64'h0000_0004);

        // 4. round robin on b: 0,1,2,0,1,2
        b_valid = 3'b111; b_res = {16'h00A2, 16'h00A1, 16'h00A0}; b_idx = 12'h321;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_ready", 64'(b_ready), 64'(rr_exp[i]));
            tick();
            chk("rr_res", 64'(b_out_res), 64'h00A0 + 64'(i % 3));
        end
        chk("rr_cnt", 64'(b_cnt), 64'h222);
        b_valid = 3'b110;
        #1;
        chk("rr_skip", 64'(b_ready), 64'h2);
        tick();
        b_valid = 3'b011;
        #1;
        chk("rr_wrap", 64'(b_ready), 64'h1);
        tick();
        chk("rr_cnt2", 64'(b_cnt), 64'h233);
        // 4-bit counter of src0 wraps from 15 to 0
        b_valid = 3'b001;
        for (int i = 0; i < 13; i++) tick();
        b_valid = '0;
        chk("cnt_wrap", 64'(b_cnt), 64'h230);

        // 5. register 0 write is accepted but not asserted
        a_valid = 2'b01; a_res = {16'h0, 16'h1234}; a_idx = 8'h00;
        #1;
        chk("zero_ready", 64'(a_ready), 64'h1);
        tick();
        chk("zero_act", 64'(a_act), 64'h0);
        chk("zero_fwd", 64'(a_fwd), 64'h0);
        chk("zero_cnt", 64'(a_cnt), 64'h0000_0005);
        // flush squashes the write but not the handshake
        a_res = {16'h0, 16'h5555}; a_idx = 8'h05; in_flush = 1'b1;
        #1;
        chk("flush_ready", 64'(a_ready), 64'h1);
        tick();
        in_flush = 1'b0; a_valid = '0;
        chk("flush_act", 64'(a_act), 64'h0);
        chk("flush_cnt", 64'(a_cnt), 64'h0000_0006);

        // 6. reset mid-stream with a write pending
        a_valid = 2'b01; a_res = {16'h0, 16'h7777}; a_idx = 8'h07;
        b_valid = 3'b001;
        tick();
        b_valid = '0;
        chk("pend_act", 64'(a_act), 64'h1);
        reset = 1'b0;
        #1;
        chk("async_act",   64'(a_act),   64'h0);
        chk("async_ready", 64'(a_ready), 64'h0);
        chk("async_cnt_a", 64'(a_cnt),   64'h0);
        chk("async_cnt_b", 64'(b_cnt),   64'h0);
        tick();
        reset = 1'b1;
        a_valid = '0;
        b_valid = 3'b101;
        #1;
        chk("ptr_reset", 64'(b_ready), 64'h1);
        tick();
        b_valid = '0;
        chk("post_rst_act", 64'(a_act), 64'h0);
        chk("post_rst_b",   64'(b_out_res), 64'h00A0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
